// File: rtl/cpu_ctrl_seq_if.sv
// rtl/cpu_ctrl_seq_if.sv - instruction, ALU and status bus of the CPU control sequencer
//
// Purpose: bundles every non-clock signal of cpu_ctrl_seq.
//   master modport : sequencer side (cpu_ctrl_seq)
//   slave modport  : environment side (instruction source, ALU, output sink)
// Signals:
//   instr_valid / instr_ready / instr[9:0]  instruction handshake
//   alu_a, alu_b, alu_op                    registered operands/op to the ALU
//   alu_result                              combinational ALU result
//   out_data, out_valid                     OUT port and its one-cycle strobe
//   zero_flag, halted                       status
//   retire_cnt                              retired-instruction count (CPU_RETIRE_CNT_EN only)
// Optional feature macro: CPU_RETIRE_CNT_EN

interface cpu_ctrl_seq_if #(
  parameter int DATA_W = 4
`ifdef CPU_RETIRE_CNT_EN
  , parameter int RETIRE_CNT_W = 8
`endif
);
  logic              instr_valid;
  logic              instr_ready;
  logic [9:0]        instr;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              zero_flag;
  logic              halted;
`ifdef CPU_RETIRE_CNT_EN
  logic [RETIRE_CNT_W-1:0] retire_cnt;
`endif

  modport master (
    input  instr_valid, instr, alu_result,
    output instr_ready, alu_a, alu_b, alu_op,
    output out_data, out_valid, zero_flag, halted
`ifdef CPU_RETIRE_CNT_EN
    , output retire_cnt
`endif
  );

  modport slave (
    output instr_valid, instr, alu_result,
    input  instr_ready, alu_a, alu_b, alu_op,
    input  out_data, out_valid, zero_flag, halted
`ifdef CPU_RETIRE_CNT_EN
    , input retire_cnt
`endif
  );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// rtl/cpu_ctrl_seq.sv - control/sequencer stage feeding the 4-bit CPU ALU
//
// Purpose: accepts 10-bit instructions ([9:7] opcode, [6:5] rd, [4:3] rs,
// [3:0] imm), owns the register file, drives registered operands/opcode to
// the external combinational ALU and writes the result back one cycle later.
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    cpu_ctrl_seq_if.master (instruction handshake, ALU bus, status)
// Optional feature macro: CPU_RETIRE_CNT_EN adds bus.retire_cnt.
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 LDI, 101 MOV, 110 OUT, 111 HALT.

module cpu_ctrl_seq #(
  parameter int DATA_W       = 4,
  parameter int NUM_REGS     = 4,
  parameter int RETIRE_CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_ctrl_seq_if.master bus
);

  // Elaboration-time parameter sanity: register index is only 2 bits wide.
  if (NUM_REGS < 1 || NUM_REGS > 4 || DATA_W < 1 || RETIRE_CNT_W < 1) begin : g_bad_param
    $error("cpu_ctrl_seq: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [2:0] OP_LDI  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_OUT  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [1:0]        exec_rd_q, exec_rd_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              zero_q, zero_d;
  logic              halted_q, halted_d;

  // Instruction fields; imm overlaps the low bit of rs by design.
  logic [2:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [3:0] imm;

  assign opcode = bus.instr[9:7];
  assign rd     = bus.instr[6:5];
  assign rs     = bus.instr[4:3];
  assign imm    = bus.instr[3:0];

  // Ready is gated by rst_n so that it is low for the whole reset interval,
  // not just after the first clock edge.
  logic instr_ready;
  logic accept;

  assign instr_ready = (state_q == ST_IDLE) && rst_n;
  assign accept      = bus.instr_valid && instr_ready;

  // Register file read ports; indices beyond NUM_REGS read as zero.
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;

  always_comb begin
    rd_val = '0;
    rs_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd == 2'(i)) rd_val = regs_q[i];
      if (rs == 2'(i)) rs_val = regs_q[i];
    end
  end

  // Single shared write port: used by LDI/MOV in IDLE and by ALU writeback
  // in EXEC, which are mutually exclusive.
  logic              wr_en;
  logic [1:0]        wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              retire;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    exec_rd_d   = exec_rd_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    zero_d      = zero_q;
    halted_d    = halted_q;
    wr_en       = 1'b0;
    wr_idx      = 2'd0;
    wr_data     = '0;
    retire      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (opcode)
            OP_LDI: begin
              wr_en   = 1'b1;
              wr_idx  = rd;
              wr_data = DATA_W'(imm);
              zero_d  = (DATA_W'(imm) == '0);
              retire  = 1'b1;
            end
            OP_MOV: begin
              wr_en   = 1'b1;
              wr_idx  = rd;
              wr_data = rs_val;
              zero_d  = (rs_val == '0);
              retire  = 1'b1;
            end
            OP_OUT: begin
              out_data_d  = rd_val;
              out_valid_d = 1'b1;
              retire      = 1'b1;
            end
            OP_HALT: begin
              halted_d = 1'b1;
              state_d  = ST_HALT;
              retire   = 1'b1;
            end
            default: begin
              // ADD/SUB/AND/NOT: operands are captured here, so rd == rs
              // naturally reads the pre-writeback value.
              alu_a_d   = rd_val;
              alu_b_d   = rs_val;
              alu_op_d  = opcode[1:0];
              exec_rd_d = rd;
              state_d   = ST_EXEC;
            end
          endcase
        end
      end
      ST_EXEC: begin
        wr_en   = 1'b1;
        wr_idx  = exec_rd_q;
        wr_data = bus.alu_result;
        zero_d  = (bus.alu_result == '0);
        retire  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (wr_idx == 2'(i))) regs_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 2'b00;
      exec_rd_q   <= 2'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      halted_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      exec_rd_q   <= exec_rd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      halted_q    <= halted_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

`ifdef CPU_RETIRE_CNT_EN
  // Wraps naturally; no increments occur in HALT since retire stays low.
  logic [RETIRE_CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (retire) retire_cnt_d = retire_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_cnt_q <= '0;
    else        retire_cnt_q <= retire_cnt_d;
  end

  assign bus.retire_cnt = retire_cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  assign bus.instr_ready = instr_ready;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.zero_flag   = zero_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb/tb_cpu_ctrl_seq.sv - self-checking bench for cpu_ctrl_seq
module tb_cpu_ctrl_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef CPU_RETIRE_CNT_EN
  cpu_ctrl_seq_if #(.DATA_W(4), .RETIRE_CNT_W(8)) bus ();
`else
  cpu_ctrl_seq_if #(.DATA_W(4)) bus ();
`endif

  cpu_ctrl_seq #(.DATA_W(4), .NUM_REGS(4), .RETIRE_CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int r;
    case (op)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b) + 16;
      2'd2:    r = int'(a & b);
      default: r = 15 - int'(a);
    endcase
    return 4'(r % 16);
  endfunction

  // The bench plays the role of the combinational ALU.
  always_comb bus.alu_result = ref_alu(bus.alu_a, bus.alu_b, bus.alu_op);

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction-level CPU state plus a pending writeback.
  logic [3:0] m_reg [4];
  bit         m_zero, m_halt, m_busy, m_outv;
  logic [1:0] m_pend_rd;
  logic [3:0] m_pend_val, m_out, m_a, m_b;
  logic [1:0] m_op;
  int         m_ret;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 4'h0;
    m_zero = 0; m_halt = 0; m_busy = 0; m_outv = 0;
    m_pend_rd = 0; m_pend_val = 0; m_out = 0; m_a = 0; m_b = 0; m_op = 0;
    m_ret = 0;
  endtask

  task automatic model_edge(input logic v, input logic [9:0] ins);
    logic [2:0] op;
    logic [1:0] rd, rs;
    op = ins[9:7]; rd = ins[6:5]; rs = ins[4:3];
    m_outv = 0;
    if (m_busy) begin
      m_reg[m_pend_rd] = m_pend_val;
      m_zero = (m_pend_val == 0);
      m_busy = 0;
      m_ret = (m_ret + 1) % 256;
    end else if (!m_halt && v) begin
      m_ret = (m_ret + 1) % 256;
      if (op < 4) begin
        m_a = m_reg[rd]; m_b = m_reg[rs]; m_op = op[1:0];
        m_pend_rd = rd;
        m_pend_val = ref_alu(m_reg[rd], m_reg[rs], op[1:0]);
        m_busy = 1;
        m_ret = (m_ret + 255) % 256;
      end else if (op == 4) begin
        m_reg[rd] = ins[3:0]; m_zero = (ins[3:0] == 0);
      end else if (op == 5) begin
        m_reg[rd] = m_reg[rs]; m_zero = (m_reg[rs] == 0);
      end else if (op == 6) begin
        m_out = m_reg[rd]; m_outv = 1;
      end else begin
        m_halt = 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ready"}, 32'(bus.instr_ready), 32'(rst_n && !m_busy && !m_halt));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_outv));
    chk({tag, ".out_data"}, 32'(bus.out_data), 32'(m_out));
    chk({tag, ".zero"}, 32'(bus.zero_flag), 32'(m_zero));
    chk({tag, ".halted"}, 32'(bus.halted), 32'(m_halt));
    chk({tag, ".alu_a"}, 32'(bus.alu_a), 32'(m_a));
    chk({tag, ".alu_b"}, 32'(bus.alu_b), 32'(m_b));
    chk({tag, ".alu_op"}, 32'(bus.alu_op), 32'(m_op));
`ifdef CPU_RETIRE_CNT_EN
    chk({tag, ".retire"}, 32'(bus.retire_cnt), 32'(m_ret));
`endif
  endtask

  // Called at a negedge; returns at the next negedge with outputs checked.
  task automatic step(input string tag, input logic v, input logic [9:0] ins);
    bus.instr_valid = v;
    bus.instr = ins;
    @(posedge clk);
    model_edge(v, ins);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    bus.instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [9:0] i_alu(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
    return {op, rd, rs, 3'b000};
  endfunction
  function automatic logic [9:0] i_ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {3'b100, rd, 1'b0, imm};
  endfunction
  function automatic logic [9:0] i_mov(input logic [1:0] rd, input logic [1:0] rs);
    return {3'b101, rd, rs, 3'b000};
  endfunction
  function automatic logic [9:0] i_out(input logic [1:0] rd);
    return {3'b110, rd, 5'b00000};
  endfunction

  typedef struct {
    logic       v;
    logic [9:0] ins;
    logic       rdy;
    logic       ov;
    logic [3:0] od;
    logic       z;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } vec_t;

  vec_t tbl[$];
  int   accepts;

  initial begin
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    model_reset();

    // Tests 1 and 2: expected outputs after each edge, derived by hand.
    tbl.push_back('{1, i_ldi(0, 4'h5),         1, 0, 4'h0, 0, 4'h0, 4'h0, 2'd0});
    tbl.push_back('{1, i_ldi(1, 4'h3),         1, 0, 4'h0, 0, 4'h0, 4'h0, 2'd0});
    tbl.push_back('{1, i_alu(3'b000, 0, 1),    0, 0, 4'h0, 0, 4'h5, 4'h3, 2'd0});
    tbl.push_back('{1, i_out(0),               1, 0, 4'h0, 0, 4'h5, 4'h3, 2'd0});
    tbl.push_back('{1, i_out(0),               1, 1, 4'h8, 0, 4'h5, 4'h3, 2'd0});
    tbl.push_back('{0, 10'h000,                1, 0, 4'h8, 0, 4'h5, 4'h3, 2'd0});
    tbl.push_back('{1, i_ldi(2, 4'hF),         1, 0, 4'h8, 0, 4'h5, 4'h3, 2'd0});
    tbl.push_back('{1, i_ldi(3, 4'h1),         1, 0, 4'h8, 0, 4'h5, 4'h3, 2'd0});
    tbl.push_back('{1, i_alu(3'b000, 2, 3),    0, 0, 4'h8, 0, 4'hF, 4'h1, 2'd0});
    tbl.push_back('{0, 10'h000,                1, 0, 4'h8, 1, 4'hF, 4'h1, 2'd0});
    tbl.push_back('{1, i_alu(3'b001, 2, 3),    0, 0, 4'h8, 1, 4'h0, 4'h1, 2'd1});
    tbl.push_back('{0, 10'h000,                1, 0, 4'h8, 0, 4'h0, 4'h1, 2'd1});
    tbl.push_back('{1, i_out(2),               1, 1, 4'hF, 0, 4'h0, 4'h1, 2'd1});
    tbl.push_back('{0, 10'h000,                1, 0, 4'hF, 0, 4'h0, 4'h1, 2'd1});

    do_reset("reset0");
    chk("reset.halted", 32'(bus.halted), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      step("tbl_model", tbl[i].v, tbl[i].ins);
      chk($sformatf("tbl%0d.ready", i), 32'(bus.instr_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d.out_data", i), 32'(bus.out_data), 32'(tbl[i].od));
      chk($sformatf("tbl%0d.zero", i), 32'(bus.zero_flag), 32'(tbl[i].z));
      chk($sformatf("tbl%0d.alu_a", i), 32'(bus.alu_a), 32'(tbl[i].a));
      chk($sformatf("tbl%0d.alu_b", i), 32'(bus.alu_b), 32'(tbl[i].b));
      chk($sformatf("tbl%0d.alu_op", i), 32'(bus.alu_op), 32'(tbl[i].op));
`ifdef CPU_RETIRE_CNT_EN
      if (i == 4) chk("tbl.retire_after_test1", 32'(bus.retire_cnt), 32'd4);
`endif
    end

    // Test 3: back-to-back ALU ops with valid held high.
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.instr_ready) accepts++;
      step("b2b", 1'b1, i_alu(3'b000, 0, 1));
    end
    chk("b2b.accepts", 32'(accepts), 32'd5);

    // Test 4: NOT, MOV, AND.
    step("t4", 1'b1, i_ldi(1, 4'hA));
    step("t4", 1'b1, i_alu(3'b011, 1, 1));
    step("t4", 1'b0, 10'h000);
    step("t4", 1'b1, i_mov(0, 1));
    step("t4", 1'b1, i_out(0));
    chk("t4.out_not", 32'(bus.out_data), 32'h5);
    step("t4", 1'b1, i_alu(3'b010, 0, 1));
    step("t4", 1'b0, 10'h000);
    step("t4", 1'b1, i_out(0));
    chk("t4.out_and", 32'(bus.out_data), 32'h5);

    // Test 5: HALT blocks further instructions; reset clears it.
    step("t5", 1'b1, {3'b111, 7'b0});
    chk("t5.halted", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 3; i++) step("t5", 1'b1, i_ldi(0, 4'h7));
    for (int i = 0; i < 2; i++) begin
      step("t5", 1'b1, i_out(0));
      chk("t5.no_out", 32'(bus.out_valid), 32'd0);
      chk("t5.ready", 32'(bus.instr_ready), 32'd0);
    end
    do_reset("t5.reset");
    chk("t5.halted_cleared", 32'(bus.halted), 32'd0);

    // Test 6: reset during EXEC drops the writeback.
    step("t6", 1'b1, i_ldi(0, 4'h2));
    step("t6", 1'b1, i_ldi(1, 4'h2));
    step("t6", 1'b1, i_alu(3'b000, 0, 1));
    chk("t6.in_exec", 32'(bus.instr_ready), 32'd0);
    do_reset("t6.reset");
    chk("t6.alu_a_cleared", 32'(bus.alu_a), 32'd0);
`ifdef CPU_RETIRE_CNT_EN
    chk("t6.retire_cleared", 32'(bus.retire_cnt), 32'd0);
`endif
    step("t6", 1'b1, i_out(0));
    chk("t6.r0_zero", 32'(bus.out_data), 32'd0);
    chk("t6.out_pulse", 32'(bus.out_valid), 32'd1);

    // Randomized run against the model.
    for (int n = 0; n < 600; n++) begin
      logic [9:0] ins;
      logic       v;
      ins = 10'($urandom);
      if (ins[9:7] == 3'b111 && ($urandom % 6) != 0) ins[9:7] = 3'($urandom % 7);
      v = (($urandom % 4) != 0);
      if ((m_halt && ($urandom % 5) == 0) || ($urandom % 150) == 0) do_reset("rnd.reset");
      step("rnd", v, ins);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
